keypad_encoder: RTL
===================

# keypad_encoder

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and turns each accepted key into a one-cycle opcode strobe plus an accumulated decimal operand. It produces the 3-bit opcode stream and the number value that the calculator control FSM and datapath consume. Opcode encoding:
- 000 idle
- 001 number
- 010 enter
- 011 clear
- 100 add, 101 sub, 110 mul, 111 div

## Interface
- SCAN_DIV, 4: clk cycles each column is driven; must be >= 4.
- DEBOUNCE_SCANS, 3: consecutive identical full-scan results needed to accept a press or release; must be >= 1.
- WIDTH, 16: width of number_out.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows; active-low, pulled up, asynchronous to clk.
- col_out  out  4  column drive; active-low, exactly one column low at a time.
- opcode_out  out  3  one-cycle opcode strobe; 000 when no event.
- number_out  out  WIDTH  accumulated unsigned decimal operand.
- key_code  out  4  index (row*4+col) of the last accepted key, for debug.

## Operation
- Key map (row, col 0..3):
  - r0: 1 2 3 add
  - r1: 4 5 6 sub
  - r2: 7 8 9 mul
  - r3: clear 0 enter div
- Scan:
  - row_in passes through a 2-flop synchronizer.
  - col_out rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110; it advances every SCAN_DIV cycles.
  - Synchronized rows are sampled in the last cycle of each column period.
- Full scan = 4 column periods. At the end of each full scan the result is one of:
  - none: no key seen;
  - single: exactly one key seen, identified by its index;
  - multi: two or more keys seen.
- FSM states (evaluated only at full-scan end, except EMIT):
  - IDLE: single -> PRESS_DB with cnt=1 and candidate latched. none/multi -> stay.
  - PRESS_DB: same single key -> cnt+1; on reaching DEBOUNCE_SCANS -> EMIT. Any other result -> IDLE with cnt cleared.
  - EMIT: lasts exactly one cycle. Drives opcode_out and updates number_out/key_code, then -> HELD.
  - HELD: none -> REL_DB with cnt=1. Anything else -> stay; a held key never repeats.
  - REL_DB: none -> cnt+1; on reaching DEBOUNCE_SCANS -> IDLE. Anything else -> HELD.
- Rules applied at EMIT:
  - Digit d:
    - If new_entry is set, number <= d and new_entry is cleared.
    - Otherwise number <= number*10 + d, computed at WIDTH+4 bits.
    - If that result exceeds 2^WIDTH-1, the digit is dropped: number is unchanged and opcode_out stays 000. The FSM still goes to HELD.
    - Otherwise opcode_out = 001.
  - Enter or operator: opcode_out = 010 or 1xx; number_out is held; new_entry is set.
  - Clear: opcode_out = 011; number <= 0; new_entry is set.
- number_out and opcode_out are registered on the same edge, so number_out is valid whenever opcode_out = 001.
- Reset values:
  - col_out = 1110, opcode_out = 000, number_out = 0, key_code = 0.
  - State IDLE, all counters 0, new_entry = 1.
- Reset asserted mid-operation (any state): all outputs and state return to reset values immediately. A key still held after reset is released is treated as a fresh press.

## Timing
- A full scan takes 4*SCAN_DIV cycles.
- Press latency: the opcode strobe appears 1 cycle after the full-scan end at which cnt reaches DEBOUNCE_SCANS. With a clean press from time 0 this is at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
- opcode_out is nonzero for exactly one cycle per accepted press, and is never nonzero on two consecutive cycles.
- A release needs DEBOUNCE_SCANS consecutive none scans before the next press can start debouncing. Minimum press-to-press spacing is 2*DEBOUNCE_SCANS full scans.
- Bounce shorter than one full scan at the press edge restarts debounce and never produces a duplicate strobe.
- There is no backpressure: the consumer must sample opcode_out on every clk.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=3, WIDTH=16 (a full scan is 16 cycles).
1. Reset: hold reset low, then release it → col_out=1110, opcode_out=000, number_out=0. col_out then rotates every 4 cycles.
2. Press key 7 cleanly for 200 cycles, then release → exactly one opcode_out=001 pulse with number_out=7. No further pulses while held or after release.
3. Press sequence 1,2,3, then add, then 4, each press/release cleanly separated → pulses 001/1, 001/12, 001/123, 100/123, 001/4. number_out restarts after the operator.
4. Enter digits 6,5,5,3,5, then 9 → 6553 is accepted and reaches 65535. The final 9 is dropped: no pulse, number_out stays 65535. Then press clear → pulse 011, number_out=0.
5. Toggle the key-5 row line every 10 cycles for 100 cycles, then hold it steady → no pulse during bouncing, exactly one 001/5 pulse after the line stabilizes.
6. Press keys 2 and 3 together, then release 3 while keeping 2 held, and assert reset mid-HELD → no pulse while both are held, then one 001/2 pulse. After reset deasserts with 2 still held, one new 001/2 pulse follows.

Source files
------------

// File: rtl/keypad_encoder.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits a one-cycle opcode strobe per accepted key and accumulates a decimal operand.
module keypad_encoder #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int WIDTH          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       row_in,
   output logic [3:0]       col_out,
   output logic [2:0]       opcode_out,
   output logic [WIDTH-1:0] number_out,
   output logic [3:0]       key_code
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

   localparam logic [1:0] RES_NONE   = 2'd0;
   localparam logic [1:0] RES_SINGLE = 2'd1;
   localparam logic [1:0] RES_MULTI  = 2'd2;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRESS_DB = 3'd1;
   localparam logic [2:0] S_EMIT     = 3'd2;
   localparam logic [2:0] S_HELD     = 3'd3;
   localparam logic [2:0] S_REL_DB   = 3'd4;

   localparam logic [2:0] OP_NUMBER = 3'b001;
   localparam logic [2:0] OP_CLEAR  = 3'b011;

   logic [3:0]       row_meta_q, row_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       scan_n_q, scan_n_d;
   logic [3:0]       scan_key_q, scan_key_d;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cand_q, cand_d;
   logic             new_entry_q, new_entry_d;
   logic [2:0]       opcode_q, opcode_d;
   logic [WIDTH-1:0] number_q, number_d;
   logic [3:0]       key_code_q, key_code_d;

   logic             sample_en, scan_end;
   logic [1:0]       hit_n, res_n;
   logic [3:0]       hit_key, res_key;
   logic [2:0]       sum_n;

   logic             key_is_digit;
   logic [3:0]       key_digit;
   logic [2:0]       key_op;
   logic [WIDTH+3:0] prod;

   assign col_out    = ~(4'b0001 << col_q);
   assign opcode_out = opcode_q;
   assign number_out = number_q;
   assign key_code   = key_code_q;

   // Column rotation and per-scan accumulation; the current column's sample is
   // merged combinationally so the scan result is available on the scan-end cycle.
   always_comb begin
      sample_en = (div_q == DIV_LAST);
      scan_end  = sample_en && (col_q == 2'd3);
      div_d     = sample_en ? '0 : div_q + 1'b1;
      col_d     = sample_en ? col_q + 2'd1 : col_q;

      hit_n   = 2'd0;
      hit_key = 4'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync_q[r]) begin
            if (hit_n == 2'd0) hit_key = {2'(r), col_q};
            if (hit_n != 2'd2) hit_n = hit_n + 2'd1;
         end
      end

      sum_n   = {1'b0, scan_n_q} + {1'b0, hit_n};
      res_n   = (sum_n >= 3'd2) ? RES_MULTI : sum_n[1:0];
      res_key = (scan_n_q == 2'd0) ? hit_key : scan_key_q;

      scan_n_d   = scan_n_q;
      scan_key_d = scan_key_q;
      if (sample_en) begin
         scan_n_d   = scan_end ? 2'd0 : res_n;
         scan_key_d = scan_end ? 4'd0 : res_key;
      end
   end

   always_comb begin
      key_is_digit = 1'b1;
      key_digit    = 4'd0;
      key_op       = 3'b000;
      case (cand_q)
         4'd0:    key_digit = 4'd1;
         4'd1:    key_digit = 4'd2;
         4'd2:    key_digit = 4'd3;
         4'd4:    key_digit = 4'd4;
         4'd5:    key_digit = 4'd5;
         4'd6:    key_digit = 4'd6;
         4'd8:    key_digit = 4'd7;
         4'd9:    key_digit = 4'd8;
         4'd10:   key_digit = 4'd9;
         4'd13:   key_digit = 4'd0;
         4'd3:    begin key_is_digit = 1'b0; key_op = 3'b100; end
         4'd7:    begin key_is_digit = 1'b0; key_op = 3'b101; end
         4'd11:   begin key_is_digit = 1'b0; key_op = 3'b110; end
         4'd15:   begin key_is_digit = 1'b0; key_op = 3'b111; end
         4'd12:   begin key_is_digit = 1'b0; key_op = OP_CLEAR; end
         default: begin key_is_digit = 1'b0; key_op = 3'b010; end
      endcase
      prod = ({4'b0000, number_q} * (WIDTH+4)'(10)) + (WIDTH+4)'(key_digit);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      new_entry_d = new_entry_q;
      opcode_d    = 3'b000;
      number_d    = number_q;
      key_code_d  = key_code_q;

      case (state_q)
         S_IDLE: begin
            if (scan_end && res_n == RES_SINGLE) begin
               cand_d = res_key;
               if (CNT_ONE == CNT_LAST) begin
                  state_d = S_EMIT;
                  cnt_d   = '0;
               end else begin
                  state_d = S_PRESS_DB;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         S_PRESS_DB: begin
            if (scan_end) begin
               if (res_n == RES_SINGLE && res_key == cand_q) begin
                  if (cnt_q + CNT_ONE == CNT_LAST) begin
                     state_d = S_EMIT;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         S_EMIT: begin
            state_d    = S_HELD;
            cnt_d      = '0;
            key_code_d = cand_q;
            if (key_is_digit) begin
               if (new_entry_q) begin
                  number_d    = WIDTH'(key_digit);
                  new_entry_d = 1'b0;
                  opcode_d    = OP_NUMBER;
               end else if (prod[WIDTH+3:WIDTH] == 4'd0) begin
                  // Digits that would overflow the operand are silently dropped.
                  number_d = prod[WIDTH-1:0];
                  opcode_d = OP_NUMBER;
               end
            end else begin
               opcode_d    = key_op;
               new_entry_d = 1'b1;
               if (key_op == OP_CLEAR) number_d = '0;
            end
         end
         S_HELD: begin
            if (scan_end && res_n == RES_NONE) begin
               if (CNT_ONE == CNT_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = S_REL_DB;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         S_REL_DB: begin
            if (scan_end) begin
               if (res_n == RES_NONE) begin
                  if (cnt_q + CNT_ONE == CNT_LAST) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  state_d = S_HELD;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta_q  <= 4'hF;
         row_sync_q  <= 4'hF;
         div_q       <= '0;
         col_q       <= 2'd0;
         scan_n_q    <= 2'd0;
         scan_key_q  <= 4'd0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cand_q      <= 4'd0;
         new_entry_q <= 1'b1;
         opcode_q    <= 3'b000;
         number_q    <= '0;
         key_code_q  <= 4'd0;
      end else begin
         row_meta_q  <= row_in;
         row_sync_q  <= row_meta_q;
         div_q       <= div_d;
         col_q       <= col_d;
         scan_n_q    <= scan_n_d;
         scan_key_q  <= scan_key_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         new_entry_q <= new_entry_d;
         opcode_q    <= opcode_d;
         number_q    <= number_d;
         key_code_q  <= key_code_d;
      end
   end

endmodule
